dma_block_engine: RTL and testbench
===================================

Name: dma_block_engine

Overview:
- Parametrised successor of the CNN-side block DMA. Holds a local weight/feature RAM with a single-word write port.
- On command, gathers a block of up to BLOCK_MAX words from a programmable base address and stride into a packed output vector for the PE array.
- Adds busy/done/error handshaking, variable length and strided access.
- Sits between the host loader and the convolution/pooling datapath.

Parameters:
- ADDR_WIDTH, 16, RAM address width.
- DATA_WIDTH, 16, word width; signed fixed-point, passed through unmodified.
- MEM_DEPTH, 2560, number of RAM words; must be ≤ 2^ADDR_WIDTH.
- BLOCK_MAX, 25, maximum words per block; equals the number of output slots.
- LEN_WIDTH, 5, width of len; must satisfy 2^LEN_WIDTH > BLOCK_MAX.
- STRIDE_WIDTH, 8, width of stride.

Ports:
- clk, input, 1, system clock; all state updates on its rising edge.
- rst, input, 1, asynchronous, active-high reset.
- wr_en, input, 1, write strobe; honoured only while idle.
- wr_addr, input, ADDR_WIDTH, write address.
- wr_data, input, DATA_WIDTH, write data.
- start, input, 1, block-read command; honoured only while idle.
- base_addr, input, ADDR_WIDTH, address of slot 0.
- len, input, LEN_WIDTH, number of words to gather.
- stride, input, STRIDE_WIDTH, address increment between slots; 0 repeats base_addr.
- busy, output, 1, high while a command executes.
- done, output, 1, one-cycle pulse when the block is complete.
- err, output, 1, one-cycle pulse when a command or write is rejected.
- block_valid, output, 1, block_data holds a complete block.
- block_data, output, BLOCK_MAX*DATA_WIDTH, slot k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset (asynchronous, any cycle, including mid-command):
  - FSM goes to IDLE.
  - busy, done, err and block_valid go to 0; block_data goes to all zeros.
  - Any partial block is discarded. RAM contents are not touched by reset.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - wr_en=1 and wr_addr < MEM_DEPTH: write RAM[wr_addr] at this edge.
  - wr_en=1 and wr_addr ≥ MEM_DEPTH: no write; err pulses.
  - start=1: command check, in priority order:
    - len=0: go to DONE; block_data is cleared to zero.
    - len > BLOCK_MAX, or base_addr + (len-1)*stride ≥ MEM_DEPTH (evaluated at full width, no wrap): err pulses the next cycle; stay IDLE; block_data and block_valid unchanged.
    - Otherwise: latch base_addr, len and stride; clear block_valid and block_data; go to READ.
  - wr_en and start in the same cycle: the write commits at that edge, so the block read observes the new data.
- READ:
  - busy=1.
  - Cycle i (i = 0..len-1) issues a synchronous RAM read at base + i*stride.
  - Read data returns one cycle later into slot i.
  - After issuing i = len-1, go to DRAIN.
- DRAIN: busy=1. The last read data is captured into slot len-1; go to DONE.
- DONE:
  - busy=0; done=1 for exactly this cycle; block_valid goes to 1.
  - Return to IDLE.
- Slots len..BLOCK_MAX-1 read as zero.
- Latency: start accepted at edge T gives done high in cycle T+len+2 (T+1 when len=0). Throughput is one word per cycle.
- While busy: wr_en and start are ignored silently (no err, no write). The host must gate on busy.
- block_valid and block_data hold their values until the next accepted start or a reset.
- err is a one-cycle pulse. It never coincides with done and never changes busy.
- No arithmetic is applied to data. Address arithmetic is unsigned, at ADDR_WIDTH+STRIDE_WIDTH+LEN_WIDTH bits.

Test Plan:
1. Reset, then write RAM[0..3] = 5, 3, 8, 0x0400; start base=0, len=4, stride=1 → done exactly 6 cycles after the start edge; slots 0..3 = 5, 3, 8, 0x0400; slots 4..24 = 0; block_valid=1.
2. Write RAM[10 + 4k] = k + 1 for k = 0..24; start base=10, len=25, stride=4 → block_data slot k = k + 1; busy high for 26 cycles.
3. Rejections:
   - start len=26 → err pulse one cycle later; busy never rises; previous block unchanged.
   - base=2550, len=11, stride=1 → err (last address 2560).
   - wr_addr=2560 → err; no write.
4. Same-cycle write and start: wr_en with addr 7 = 0xF000 together with start base=7, len=1 → slot 0 = 0xF000.
5. Mid-block: during READ assert wr_en addr 0 = 0x1111 and a second start → both ignored; RAM[0] unchanged; first block completes correctly. Then assert rst during READ of a new block → busy=0, block_valid=0, block_data=0 asynchronously; next command behaves normally.
6. len=0 → done one cycle after start; block_data all zero; block_valid=1. stride=0, base=5, len=3 → three copies of RAM[5].

Source files
------------

// File: rtl/dma_block_engine_if.sv
// Host-side bundle for dma_block_engine: RAM write port, block command and block result.
interface dma_block_engine_if #(
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned BLOCK_MAX    = 25,
    parameter int unsigned LEN_WIDTH    = 5,
    parameter int unsigned STRIDE_WIDTH = 8
);
    logic                              wr_en;
    logic [ADDR_WIDTH-1:0]             wr_addr;
    logic [DATA_WIDTH-1:0]             wr_data;
    logic                              start;
    logic [ADDR_WIDTH-1:0]             base_addr;
    logic [LEN_WIDTH-1:0]              len;
    logic [STRIDE_WIDTH-1:0]           stride;
    logic                              busy;
    logic                              done;
    logic                              err;
    logic                              block_valid;
    logic [BLOCK_MAX*DATA_WIDTH-1:0]   block_data;

    modport master (
        output wr_en, wr_addr, wr_data, start, base_addr, len, stride,
        input  busy, done, err, block_valid, block_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, base_addr, len, stride,
        output busy, done, err, block_valid, block_data
    );
endinterface

// File: rtl/dma_block_engine.sv
// Local weight/feature RAM with a strided block gather into a packed slot vector.
module dma_block_engine #(
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned MEM_DEPTH    = 2560,
    parameter int unsigned BLOCK_MAX    = 25,
    parameter int unsigned LEN_WIDTH    = 5,
    parameter int unsigned STRIDE_WIDTH = 8
) (
    input logic              clk,
    input logic              rst,
    dma_block_engine_if.slave bus
);
    localparam int unsigned MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned FW     = ADDR_WIDTH + STRIDE_WIDTH + LEN_WIDTH;
    localparam int unsigned BW     = BLOCK_MAX * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [MEM_AW-1:0]       addr_q, addr_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic [STRIDE_WIDTH-1:0] stride_q, stride_d;
    logic [LEN_WIDTH-1:0]    idx_q, idx_d;
    logic                    rd_vld_q, rd_vld_d;
    logic [LEN_WIDTH-1:0]    rd_slot_q, rd_slot_d;
    logic [BW-1:0]           block_data_q, block_data_d;
    logic                    block_valid_q, block_valid_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   rd_data_q;

    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    logic          idle;
    logic          wr_ok, wr_bad;
    logic          cmd_zero, cmd_bad, cmd_go;
    logic [FW-1:0] last_addr;

    assign idle = (state_q == IDLE);

    // Last gathered address computed wide enough that it can never wrap.
    assign last_addr = FW'(bus.base_addr)
                     + FW'(bus.len - LEN_WIDTH'(1)) * FW'(bus.stride);

    assign wr_ok    = idle && bus.wr_en && (32'(bus.wr_addr) < MEM_DEPTH);
    assign wr_bad   = idle && bus.wr_en && !(32'(bus.wr_addr) < MEM_DEPTH);
    assign cmd_zero = idle && bus.start && (bus.len == '0);
    assign cmd_bad  = idle && bus.start && (bus.len != '0)
                   && ((32'(bus.len) > BLOCK_MAX) || (last_addr >= FW'(MEM_DEPTH)));
    assign cmd_go   = idle && bus.start && (bus.len != '0) && !cmd_bad;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[MEM_AW'(bus.wr_addr)] <= bus.wr_data;
        end
        rd_data_q <= mem[addr_q];
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        len_d         = len_q;
        stride_d      = stride_q;
        idx_d         = idx_q;
        rd_vld_d      = 1'b0;
        rd_slot_d     = rd_slot_q;
        block_data_d  = block_data_q;
        block_valid_d = block_valid_q;
        // A zero-length command finishes next cycle, so its write error is dropped to keep err off done.
        err_d         = cmd_bad || (wr_bad && !cmd_zero);

        if (rd_vld_q) begin
            block_data_d[rd_slot_q*DATA_WIDTH +: DATA_WIDTH] = rd_data_q;
        end

        unique case (state_q)
            IDLE: begin
                if (cmd_zero) begin
                    block_data_d  = '0;
                    block_valid_d = 1'b1;
                    state_d       = DONE;
                end else if (cmd_go) begin
                    addr_d        = MEM_AW'(bus.base_addr);
                    len_d         = bus.len;
                    stride_d      = bus.stride;
                    idx_d         = '0;
                    block_data_d  = '0;
                    block_valid_d = 1'b0;
                    state_d       = READ;
                end
            end
            READ: begin
                rd_vld_d  = 1'b1;
                rd_slot_d = idx_q;
                addr_d    = addr_q + MEM_AW'(stride_q);
                idx_d     = idx_q + LEN_WIDTH'(1);
                if (idx_q == len_q - LEN_WIDTH'(1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                block_valid_d = 1'b1;
                state_d       = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            len_q         <= '0;
            stride_q      <= '0;
            idx_q         <= '0;
            rd_vld_q      <= 1'b0;
            rd_slot_q     <= '0;
            block_data_q  <= '0;
            block_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            stride_q      <= stride_d;
            idx_q         <= idx_d;
            rd_vld_q      <= rd_vld_d;
            rd_slot_q     <= rd_slot_d;
            block_data_q  <= block_data_d;
            block_valid_q <= block_valid_d;
            err_q         <= err_d;
        end
    end

    assign bus.busy        = (state_q == READ) || (state_q == DRAIN);
    assign bus.done        = (state_q == DONE);
    assign bus.err         = err_q;
    assign bus.block_valid = block_valid_q;
    assign bus.block_data  = block_data_q;
endmodule

// File: tb/tb_dma_block_engine.sv
// Directed self-checking bench for dma_block_engine.
module tb_dma_block_engine;
    localparam int AW = 16, DW = 16, DEPTH = 2560, BMAX = 25, LW = 5, SW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dma_block_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_MAX(BMAX),
                          .LEN_WIDTH(LW), .STRIDE_WIDTH(SW)) bus ();

    dma_block_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH),
                       .BLOCK_MAX(BMAX), .LEN_WIDTH(LW), .STRIDE_WIDTH(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [BMAX*DW-1:0] t1_blk, t2_blk, exp_blk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.start = 1'b0; bus.base_addr = '0; bus.len = '0; bus.stride = '0;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    // Issues a command (wr_en may be preset by the caller) and waits for done.
    task automatic run_cmd(input logic [AW-1:0] b, input logic [LW-1:0] l,
                           input logic [SW-1:0] s, output int lat, output int bcnt);
        bus.start = 1'b1; bus.base_addr = b; bus.len = l; bus.stride = s;
        tick();
        bus.start = 1'b0; bus.wr_en = 1'b0;
        lat = 0; bcnt = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (bus.busy === 1'b1) bcnt++;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus.err); end
        checks++; if (bus.block_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.block_valid); end
        checks++; if (bus.block_data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", bus.block_data); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        int lat, bcnt;
        write_word(16'd0, 16'd5);
        write_word(16'd1, 16'd3);
        write_word(16'd2, 16'd8);
        write_word(16'd3, 16'h0400);
        t1_blk = '0;
        t1_blk[0*DW +: DW] = 16'd5;
        t1_blk[1*DW +: DW] = 16'd3;
        t1_blk[2*DW +: DW] = 16'd8;
        t1_blk[3*DW +: DW] = 16'h0400;
        run_cmd(16'd0, 5'd4, 8'd1, lat, bcnt);
        checks++; if (lat !== 5) begin errors++; $display("FAIL basic_latency got=%0d exp=5", lat); end
        checks++; if (bcnt !== 5) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=5", bcnt); end
        checks++; if (bus.block_data !== t1_blk) begin errors++; $display("FAIL basic_data got=%h exp=%h", bus.block_data, t1_blk); end
        checks++; if (bus.block_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", bus.block_valid); end
        tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b exp=0", bus.done); end
    endtask

    task automatic test_stride;
        int lat, bcnt;
        t2_blk = '0;
        for (int k = 0; k < 25; k++) begin
            write_word(16'(10 + 4*k), 16'(k + 1));
            t2_blk[k*DW +: DW] = 16'(k + 1);
        end
        run_cmd(16'd10, 5'd25, 8'd4, lat, bcnt);
        checks++; if (lat !== 26) begin errors++; $display("FAIL stride_latency got=%0d exp=26", lat); end
        checks++; if (bcnt !== 26) begin errors++; $display("FAIL stride_busy_cycles got=%0d exp=26", bcnt); end
        checks++; if (bus.block_data !== t2_blk) begin errors++; $display("FAIL stride_data got=%h exp=%h", bus.block_data, t2_blk); end
        tick();
    endtask

    task automatic test_reject;
        int lat, bcnt;
        bus.start = 1'b1; bus.base_addr = 16'd0; bus.len = 5'd26; bus.stride = 8'd1;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL rej_len_err got=%b exp=1", bus.err); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rej_len_busy got=%b exp=0", bus.busy); end
        tick();
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rej_err_pulse got=%b exp=0", bus.err); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rej_len_busy2 got=%b exp=0", bus.busy); end
        checks++; if (bus.block_data !== t2_blk) begin errors++; $display("FAIL rej_block_kept got=%h exp=%h", bus.block_data, t2_blk); end
        checks++; if (bus.block_valid !== 1'b1) begin errors++; $display("FAIL rej_valid_kept got=%b exp=1", bus.block_valid); end

        bus.start = 1'b1; bus.base_addr = 16'd2550; bus.len = 5'd11; bus.stride = 8'd1;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL rej_range_err got=%b exp=1", bus.err); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rej_range_busy got=%b exp=0", bus.busy); end
        tick();

        write_word(16'd2560, 16'h5A5A);
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL rej_wr_err got=%b exp=1", bus.err); end
        tick();

        write_word(16'd2559, 16'hABCD);
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL edge_wr_err got=%b exp=0", bus.err); end
        run_cmd(16'd2559, 5'd1, 8'd7, lat, bcnt);
        exp_blk = '0;
        exp_blk[0 +: DW] = 16'hABCD;
        checks++; if (lat !== 2) begin errors++; $display("FAIL edge_latency got=%0d exp=2", lat); end
        checks++; if (bus.block_data !== exp_blk) begin errors++; $display("FAIL edge_data got=%h exp=%h", bus.block_data, exp_blk); end
        tick();
    endtask

    task automatic test_same_cycle;
        int lat, bcnt;
        bus.wr_en = 1'b1; bus.wr_addr = 16'd7; bus.wr_data = 16'hF000;
        run_cmd(16'd7, 5'd1, 8'd1, lat, bcnt);
        exp_blk = '0;
        exp_blk[0 +: DW] = 16'hF000;
        checks++; if (lat !== 2) begin errors++; $display("FAIL same_latency got=%0d exp=2", lat); end
        checks++; if (bus.block_data !== exp_blk) begin errors++; $display("FAIL same_data got=%h exp=%h", bus.block_data, exp_blk); end
        tick();
    endtask

    task automatic test_mid_block;
        int lat, bcnt;
        bus.start = 1'b1; bus.base_addr = 16'd10; bus.len = 5'd25; bus.stride = 8'd4;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        bus.wr_en = 1'b1; bus.wr_addr = 16'd0; bus.wr_data = 16'h1111;
        bus.start = 1'b1; bus.base_addr = 16'd0; bus.len = 5'd1; bus.stride = 8'd1;
        tick();
        bus.wr_en = 1'b0; bus.start = 1'b0;
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL mid_err got=%b exp=0", bus.err); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b exp=1", bus.busy); end
        lat = 3;
        while (bus.done !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        checks++; if (lat !== 26) begin errors++; $display("FAIL mid_latency got=%0d exp=26", lat); end
        checks++; if (bus.block_data !== t2_blk) begin errors++; $display("FAIL mid_data got=%h exp=%h", bus.block_data, t2_blk); end
        tick();
        run_cmd(16'd0, 5'd1, 8'd1, lat, bcnt);
        checks++; if (bus.block_data[0 +: DW] !== 16'd5) begin errors++; $display("FAIL mid_ram0_kept got=%h exp=0005", bus.block_data[0 +: DW]); end
        tick();

        bus.start = 1'b1; bus.base_addr = 16'd10; bus.len = 5'd25; bus.stride = 8'd4;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL arst_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.block_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got=%b exp=0", bus.block_valid); end
        checks++; if (bus.block_data !== '0) begin errors++; $display("FAIL arst_data got=%h exp=0", bus.block_data); end
        rst = 1'b0;
        tick();
        run_cmd(16'd0, 5'd4, 8'd1, lat, bcnt);
        checks++; if (lat !== 5) begin errors++; $display("FAIL post_rst_latency got=%0d exp=5", lat); end
        checks++; if (bus.block_data !== t1_blk) begin errors++; $display("FAIL post_rst_data got=%h exp=%h", bus.block_data, t1_blk); end
        tick();
    endtask

    task automatic test_len_stride_zero;
        int lat, bcnt;
        run_cmd(16'd0, 5'd0, 8'd1, lat, bcnt);
        checks++; if (lat !== 0) begin errors++; $display("FAIL len0_latency got=%0d exp=0", lat); end
        checks++; if (bus.block_data !== '0) begin errors++; $display("FAIL len0_data got=%h exp=0", bus.block_data); end
        checks++; if (bus.block_valid !== 1'b1) begin errors++; $display("FAIL len0_valid got=%b exp=1", bus.block_valid); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL len0_err got=%b exp=0", bus.err); end
        tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL len0_done_pulse got=%b exp=0", bus.done); end

        write_word(16'd5, 16'h0BEE);
        run_cmd(16'd5, 5'd3, 8'd0, lat, bcnt);
        exp_blk = '0;
        exp_blk[0*DW +: DW] = 16'h0BEE;
        exp_blk[1*DW +: DW] = 16'h0BEE;
        exp_blk[2*DW +: DW] = 16'h0BEE;
        checks++; if (lat !== 4) begin errors++; $display("FAIL stride0_latency got=%0d exp=4", lat); end
        checks++; if (bus.block_data !== exp_blk) begin errors++; $display("FAIL stride0_data got=%h exp=%h", bus.block_data, exp_blk); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stride();
        test_reject();
        test_same_cycle();
        test_mid_block();
        test_len_stride_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
